// File: rtl/fft_input_loader.sv
// Serial-to-parallel frame loader feeding the 8-point radix-2 FFT datapath.
// Latency: the 8th sample accepted at edge t is visible in parallel after edge t, unless the other bank is still pending.
// Backpressure: in_ready drops while the write bank is full; a presented frame is held until out_ready.
//
// Ports:
//   clk_1              system clock, rising edge
//   rst                synchronous active-high reset
//   flush              discard the partially filled write frame
//   in_data/in_valid   serial sample input
//   in_ready           a sample can be accepted this cycle
//   out1..out8         frame slots 0..7 (zero when out_valid is low)
//   out_valid          out1..out8 hold a complete frame
//   out_ready          consumer takes the presented frame this cycle
//   wr_count           samples already written into the current write frame
module fft_input_loader #(
   parameter int WIDTH       = 8,
   parameter bit BIT_REVERSE = 1'b1
) (
   input  logic             clk_1,
   input  logic             rst,
   input  logic             flush,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [WIDTH-1:0] out4,
   output logic [WIDTH-1:0] out5,
   output logic [WIDTH-1:0] out6,
   output logic [WIDTH-1:0] out7,
   output logic [WIDTH-1:0] out8,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       wr_count
);

   // Ping-pong storage: one bank fills while the other is presented.
   logic [WIDTH-1:0] r_bank [0:1][0:7];
   logic [1:0]       r_full;
   logic             r_wr_sel;
   logic             r_rd_sel;
   logic [2:0]       r_wr_cnt;

   logic             w_in_ready;
   logic             w_wr_en;
   logic             w_wr_last;
   logic             w_out_valid;
   logic             w_rd_en;
   logic [2:0]       w_wr_slot;
   logic [1:0]       w_full_nxt;
   logic [WIDTH-1:0] w_rd_word [0:7];

   assign w_in_ready  = ~r_full[r_wr_sel];
   // A sample handshaken during flush belongs to the discarded frame, so it
   // neither writes nor advances the count.
   assign w_wr_en     = in_valid & w_in_ready & ~flush;
   assign w_wr_last   = w_wr_en & (r_wr_cnt == 3'd7);
   assign w_out_valid = r_full[r_rd_sel];
   assign w_rd_en     = w_out_valid & out_ready;

   // Samples land directly in the slot the butterflies read, so the read
   // side is a plain bank select with no reordering.
   assign w_wr_slot = BIT_REVERSE ? {r_wr_cnt[0], r_wr_cnt[1], r_wr_cnt[2]} : r_wr_cnt;

   // Release and completion always hit different banks: a write needs the
   // bank empty, a read needs it full.
   always_comb begin
      w_full_nxt = r_full;
      if (w_rd_en) begin
         w_full_nxt[r_rd_sel] = 1'b0;
      end
      if (w_wr_last) begin
         w_full_nxt[r_wr_sel] = 1'b1;
      end
   end

   always_ff @(posedge clk_1) begin
      if (rst) begin
         r_full   <= 2'b00;
         r_wr_sel <= 1'b0;
         r_rd_sel <= 1'b0;
         r_wr_cnt <= 3'd0;
         for (int b = 0; b < 2; b++) begin
            for (int s = 0; s < 8; s++) begin
               r_bank[b][s] <= '0;
            end
         end
      end else begin
         r_full <= w_full_nxt;
         if (w_wr_en) begin
            r_bank[r_wr_sel][w_wr_slot] <= in_data;
         end
         // The 3-bit counter wraps from 7 to 0 on frame completion.
         if (flush) begin
            r_wr_cnt <= 3'd0;
         end else if (w_wr_en) begin
            r_wr_cnt <= r_wr_cnt + 3'd1;
         end
         if (w_wr_last) begin
            r_wr_sel <= ~r_wr_sel;
         end
         if (w_rd_en) begin
            r_rd_sel <= ~r_rd_sel;
         end
      end
   end

   // Outputs are forced to zero when no frame is presented.
   always_comb begin
      for (int s = 0; s < 8; s++) begin
         w_rd_word[s] = w_out_valid ? r_bank[r_rd_sel][s] : '0;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign wr_count  = r_wr_cnt;
   assign out1      = w_rd_word[0];
   assign out2      = w_rd_word[1];
   assign out3      = w_rd_word[2];
   assign out4      = w_rd_word[3];
   assign out5      = w_rd_word[4];
   assign out6      = w_rd_word[5];
   assign out7      = w_rd_word[6];
   assign out8      = w_rd_word[7];

endmodule
